// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide unit controller.
// Owns the HI/LO architectural registers. Runs a single-cycle multiply or a
// 32-cycle restoring divide, then holds the result in DONE until the
// pipeline releases the E stage. The result is committed to HI/LO on that edge.
module mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        e_stall,
  input  logic        flush,
  output logic        mult_div_start,
  output logic        mult_div_ready,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [1:0]  state;
  logic [2:0]  op_lat;      // operation captured at accept
  logic [31:0] a_lat;
  logic [31:0] b_lat;
  logic [63:0] prod;
  logic [31:0] rem;         // partial remainder
  logic [31:0] quo;         // dividend shifts out the top, quotient bits shift in
  logic [5:0]  cnt;
  logic        div_zero;    // accepted divide had a zero divisor: commit writes nothing
  logic [31:0] hi;
  logic [31:0] lo;

  logic        is_mul_op;
  logic        is_div_op;
  logic        accept;
  logic        mt_write;
  logic        commit;
  logic [31:0] a_mag_in;
  logic [31:0] dvs_mag;
  logic [32:0] shifted;
  logic        sub_ok;
  logic [31:0] rem_sub;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod_next;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign is_mul_op      = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op      = (op == OP_DIV)  || (op == OP_DIVU);
  assign mult_div_start = op_valid && (is_mul_op || is_div_op);
  assign mult_div_ready = (state == DONE);

  assign accept   = (state == IDLE) && mult_div_start && !flush;
  assign mt_write = (state == IDLE) && op_valid && !e_stall && !flush &&
                    ((op == OP_MTHI) || (op == OP_MTLO));
  assign commit   = (state == DONE) && !e_stall && !flush && !div_zero;

  // Signed divide works on magnitudes; DIVU passes operands through untouched.
  assign a_mag_in = ((op == OP_DIV) && src_a[31]) ? -src_a : src_a;
  assign dvs_mag  = ((op_lat == OP_DIV) && b_lat[31]) ? -b_lat : b_lat;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The true difference is below the divisor, so 32 bits of it are exact.
  assign shifted = {rem, quo[31]};
  assign sub_ok  = (shifted >= {1'b0, dvs_mag});
  assign rem_sub = shifted[31:0] - dvs_mag;

  // Sign-extending to 64 bits makes one multiplier serve MULT and MULTU.
  assign a_ext     = (op_lat == OP_MULT) ? {{32{a_lat[31]}}, a_lat} : {32'd0, a_lat};
  assign b_ext     = (op_lat == OP_MULT) ? {{32{b_lat[31]}}, b_lat} : {32'd0, b_lat};
  assign prod_next = a_ext * b_ext;

  // Quotient sign is the xor of operand signs; remainder follows the dividend.
  assign q_fix = ((op_lat == OP_DIV) && (a_lat[31] ^ b_lat[31])) ? -quo : quo;
  assign r_fix = ((op_lat == OP_DIV) && a_lat[31]) ? -rem : rem;

  assign res_hi = ((op_lat == OP_MULT) || (op_lat == OP_MULTU)) ? prod[63:32] : r_fix;
  assign res_lo = ((op_lat == OP_MULT) || (op_lat == OP_MULTU)) ? prod[31:0]  : q_fix;

  // Control FSM: flush squashes from any state and beats a pending commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul_op)          state <= MUL;
            else if (src_b == 32'd0) state <= DONE;
            else                     state <= DIV;
          end
        end
        MUL:     state <= DONE;
        DIV:     if (cnt == 6'd31) state <= DONE;
        DONE:    if (!e_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture, multiply result and iterative divider datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_lat   <= 3'd0;
      a_lat    <= 32'd0;
      b_lat    <= 32'd0;
      prod     <= 64'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      cnt      <= 6'd0;
      div_zero <= 1'b0;
    end else if (accept) begin
      op_lat   <= op;
      a_lat    <= src_a;
      b_lat    <= src_b;
      rem      <= 32'd0;
      quo      <= a_mag_in;
      cnt      <= 6'd0;
      div_zero <= is_div_op && (src_b == 32'd0);
    end else if (state == MUL) begin
      prod <= prod_next;
    end else if (state == DIV) begin
      cnt <= cnt + 6'd1;
      rem <= sub_ok ? rem_sub : shifted[31:0];
      quo <= {quo[30:0], sub_ok};
    end
  end

  // HI/LO architectural registers: written by commit or by MTHI/MTLO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_write) begin
      if (op == OP_MTHI) hi <= src_a;
      else               lo <= src_a;
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for mdu_ctrl with a scoreboard queue.
// Stimulus pushes the hand-computed HI/LO and ready latency of each accepted
// mult/div; the monitor pops on ready, checks latency, tracks HI/LO on commit
// and on MTHI/MTLO, and compares hi_o/lo_o every cycle.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        e_stall = 1'b0;
  logic        flush = 1'b0;
  logic        mult_div_start;
  logic        mult_div_ready;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  mdu_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .op_valid       (op_valid),
    .op             (op),
    .src_a          (src_a),
    .src_b          (src_b),
    .e_stall        (e_stall),
    .flush          (flush),
    .mult_div_start (mult_div_start),
    .mult_div_ready (mult_div_ready),
    .hi_o           (hi_o),
    .lo_o           (lo_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          to_cnt = 0;
  bit          done_flag = 1'b0;

  // monitor-owned state
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  exp_t        cur;
  bit          have_cur = 1'b0;
  bit          commit_pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    forever begin
      @(negedge clk or negedge resetn);
      if (!resetn) begin
        #1;
        hi_m = 32'd0;
        lo_m = 32'd0;
        have_cur = 1'b0;
        commit_pend = 1'b0;
        chk("rst_ready", {63'd0, mult_div_ready}, 64'd0);
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
      end else begin
        chk("hi", {32'd0, hi_o}, {32'd0, hi_m});
        chk("lo", {32'd0, lo_o}, {32'd0, lo_m});
        chk("start", {63'd0, mult_div_start},
            {63'd0, (op_valid && (op >= 3'd1) && (op <= 3'd4))});
        if (commit_pend) begin
          chk("ready_drop", {63'd0, mult_div_ready}, 64'd0);
          commit_pend = 1'b0;
        end else if (have_cur) begin
          chk("ready_hold", {63'd0, mult_div_ready}, 64'd1);
        end else if (mult_div_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", 64'd1, 64'd0);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk({cur.name, "_latency"}, 64'(cyc - cur.acc + 1), 64'(cur.lat));
          end
        end
        if (have_cur && mult_div_ready && !e_stall && !flush) begin
          hi_m = cur.hi;
          lo_m = cur.lo;
          have_cur = 1'b0;
          commit_pend = 1'b1;
          $display("commit %s: expect hi=%08h lo=%08h", cur.name, cur.hi, cur.lo);
        end
        if (op_valid && !flush && !e_stall && (op == 3'b101)) hi_m = src_a;
        if (op_valid && !flush && !e_stall && (op == 3'b110)) lo_m = src_a;
        if (done_flag) begin
          chk("queue_empty", 64'(exp_q.size()), 64'd0);
          chk("timeouts", 64'(to_cnt), 64'd0);
          $display("%0d/%0d checks passed", n_pass, n_total);
          $finish;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div, wait for ready (bounded), hold e_stall for 'stall' ready cycles.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input int stall);
    exp_t e;
    int   i;
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    e_stall  = (stall > 0);
    e.name = nm;
    e.hi   = eh;
    e.lo   = el;
    e.lat  = lat;
    e.acc  = cyc + 1;
    exp_q.push_back(e);
    tick();
    op_valid = 1'b0;
    op       = 3'd0;
    src_a    = $urandom;
    src_b    = $urandom;
    i = 0;
    while (!mult_div_ready && i < 60) begin
      tick();
      i++;
    end
    if (!mult_div_ready) begin
      to_cnt++;
    end else begin
      if (stall > 1) repeat (stall - 1) tick();
      e_stall = 1'b0;
      tick();
    end
    e_stall = 1'b0;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    op_valid = 1'b1;
    op       = o;
    src_a    = v;
    tick();
    op_valid = 1'b0;
    op       = 3'd0;
  endtask

  initial begin : stim
    #2 resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    run_op("mult_neg",     3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2, 0);
    run_op("div_neg",      3'b011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
    run_op("divu",         3'b100, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 33, 0);
    mt(3'b101, 32'h11);
    mt(3'b110, 32'h22);
    run_op("divu_zero",    3'b100, 32'd5,        32'd0,        32'h11,       32'h22,       1, 0);
    run_op("multu_stall",  3'b010, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 2, 3);
    run_op("div_negb",     3'b011, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 0);
    run_op("div_both_neg", 3'b011, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 33, 0);
    run_op("div_plain",    3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       33, 0);
    run_op("div_min",      3'b011, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 0);
    run_op("mult_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        2, 0);
    run_op("multu_max",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2, 0);
    run_op("div_zero",     3'b011, 32'd123,      32'd0,        32'hFFFFFFFE, 32'h00000001, 1, 0);
    // undefined op codes are no-ops
    op_valid = 1'b1; op = 3'b111; src_a = 32'hDEADBEEF; src_b = 32'd1;
    tick();
    op = 3'b000;
    tick();
    op_valid = 1'b0;
    // divide squashed by flush mid-way: no ready, HI/LO untouched
    op_valid = 1'b1; op = 3'b011; src_a = 32'd1000; src_b = 32'd3;
    tick();
    op_valid = 1'b0; op = 3'd0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (40) tick();
    mt(3'b101, 32'hA5A5A5A5);
    mt(3'b110, 32'h5A5A5A5A);
    tick();
    // reset in the middle of a divide
    op_valid = 1'b1; op = 3'b011; src_a = 32'd7; src_b = 32'd3;
    tick();
    op_valid = 1'b0; op = 3'd0;
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    run_op("mult_after_rst", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 2, 0);
    repeat (3) tick();
    done_flag = 1'b1;
    repeat (5) tick();
    $display("FAIL end_of_test: monitor did not finish, got none, required summary");
    $fatal(1);
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports clk (input, 1, clock); reset is asynchronous and active-low, named resetn (input, 1).
REQ-002 SHALL have op_valid (input, 1): an E-stage instruction uses the mult/div unit.
REQ-003 SHALL have op (input, 3): 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; other codes are no-ops.
REQ-004 SHALL have src_a, src_b (input, 32 each): E-stage rs/rt operand values after forwarding.
REQ-005 SHALL have e_stall (input, 1): the E stage is held this cycle.
REQ-006 SHALL have flush (input, 1): the E-stage instruction is squashed (exception in M).
REQ-007 SHALL have mult_div_start (output, 1): combinational, op_valid & op in {001..100}, in every state.
REQ-008 SHALL have mult_div_ready (output, 1): high only in state DONE.
REQ-009 SHALL have hi_o, lo_o (output, 32 each): registered HI and LO architectural values.

Function
REQ-010 SHALL have states IDLE, MUL, DIV, DONE; reset state is IDLE.
REQ-011 In IDLE, with op_valid, a mult/div op and ~flush, SHALL latch op, src_a and src_b at the clock edge; MULT/MULTU go to MUL, DIV/DIVU go to DIV.
REQ-012 Accept SHALL occur regardless of e_stall.
REQ-013 MUL SHALL last exactly 1 cycle, registering the 64-bit product (signed for MULT, unsigned for MULTU), then go to DONE.
REQ-014 DIV SHALL use an iterative restoring divider on operand magnitudes: 1 quotient bit per cycle, 6-bit counter, exactly 32 cycles in DIV, then DONE.
REQ-015 DIV signs: quotient negated iff src_a[31]^src_b[31]; remainder takes the sign of src_a.
REQ-016 DIVU SHALL use the raw operands with no sign fix.
REQ-017 Result mapping: mult gives HI=product[63:32], LO=product[31:0]; div gives HI=remainder, LO=quotient.
REQ-018 Divisor zero SHALL skip DIV: IDLE goes straight to DONE, and HI/LO stay unchanged on commit.
REQ-019 DONE SHALL be held while e_stall=1.
REQ-020 DONE with ~e_stall SHALL go to IDLE and write HI/LO on that edge (commit).
REQ-021 Latency from accept edge to ready: mult 2 cycles; div 33 cycles; divide-by-zero 1 cycle.
REQ-022 MTHI/MTLO in IDLE with op_valid, ~e_stall and ~flush SHALL write src_a into HI/LO on that edge; they never leave IDLE or assert ready.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge, with no HI/LO write and no accept; flush wins over commit in DONE.
REQ-024 A mult/div op seen in IDLE on the cycle after a commit SHALL be treated as a new instruction and accepted.
REQ-025 Operand registers SHALL be used during MUL/DIV; src_a/src_b changes after accept SHALL have no effect.

Reset
REQ-026 resetn low SHALL immediately clear: state to IDLE, HI/LO/operand/product/counter registers to 0, mult_div_ready to 0.
REQ-027 Reset asserted mid-DIV SHALL abandon the operation; no commit occurs after release.
REQ-028 After resetn deasserts, the first accept SHALL occur no earlier than the first rising edge with resetn high.

Verification
REQ-029 MULT a=0xFFFFFFFE (-2), b=3, e_stall=0 -> ready 2 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFFA after commit.
REQ-030 DIV a=-7 (0xFFFFFFF9), b=2 -> ready exactly 33 cycles after accept; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); same with DIVU gives LO=0x7FFFFFFC, HI=1.
REQ-031 DIVU a=5, b=0 with HI=0x11, LO=0x22 -> ready 1 cycle after accept; HI/LO remain 0x11/0x22.
REQ-032 MULTU 0xFFFFFFFF*2 reaches DONE with e_stall=1 for 3 cycles -> ready held 3 cycles; HI=1, LO=0xFFFFFFFE only on the edge where e_stall drops.
REQ-033 flush pulsed at DIV cycle 10 -> IDLE next cycle, ready never asserts, HI/LO unchanged; back-to-back MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A -> hi_o/lo_o update on consecutive edges.
REQ-034 resetn pulsed low mid-DIV -> ready=0, hi_o=lo_o=0 immediately; new MULT 3*4 after release yields LO=12, HI=0.
